// File: rtl/io_terminal.sv
// io_terminal: 8N1 serial terminal behind the basic computer's INPR/OUTR, owning FGI/FGO and IRQ.
// Build option IO_TERMINAL_LOOPBACK_EN feeds the transmitter back into the receiver instead of rxd.
module io_terminal #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       rxd,
  output logic       txd,
  output logic [7:0] inp_r,
  output logic       fgi,
  input  logic       inp_ack,
  input  logic [7:0] outr_data,
  input  logic       outr_ld,
  output logic       fgo,
  input  logic       ien,
  output logic       irq,
  output logic       rx_overrun
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic             w_rx_src;
  logic             r_rx_s1, r_rx_s2;
  state_t           r_rx_state, w_rx_state_nxt;
  logic [CNT_W-1:0] r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0]       r_rx_bit, w_rx_bit_nxt;
  logic [7:0]       r_rx_shift, w_rx_shift_nxt;
  logic             w_rx_valid;

  state_t           r_tx_state, w_tx_state_nxt;
  logic [CNT_W-1:0] r_tx_cnt, w_tx_cnt_nxt;
  logic [2:0]       r_tx_bit, w_tx_bit_nxt;
  logic [7:0]       r_tx_shift, w_tx_shift_nxt;
  logic             r_txd, w_txd_nxt;
  logic             w_tx_accept, w_tx_done;

  logic             r_fgi, r_fgo, r_irq, r_ovr;
  logic [7:0]       r_inp;

`ifdef IO_TERMINAL_LOOPBACK_EN
  // rxd stays referenced but has no effect on the receiver.
  assign w_rx_src = r_txd | (rxd & 1'b0);
`else
  assign w_rx_src = rxd;
`endif

  // Receive: synchronizer, then start/data/stop sampling at bit centres.
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt + CNT_W'(1);
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_valid     = 1'b0;
    case (r_rx_state)
      S_IDLE: begin
        w_rx_cnt_nxt = '0;
        if (!r_rx_s2) w_rx_state_nxt = S_START;
      end
      S_START: begin
        if (r_rx_cnt == HALF_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_bit_nxt   = '0;
          w_rx_state_nxt = r_rx_s2 ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_rx_cnt == BIT_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_shift_nxt = {r_rx_s2, r_rx_shift[7:1]};
          w_rx_bit_nxt   = r_rx_bit + 3'd1;
          if (r_rx_bit == 3'd7) w_rx_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (r_rx_cnt == BIT_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_valid     = r_rx_s2;
          w_rx_state_nxt = S_IDLE;
        end
      end
      default: w_rx_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_state <= S_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
    end else begin
      r_rx_s1    <= w_rx_src;
      r_rx_s2    <= r_rx_s1;
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
    end
  end

  always_ff @(posedge clk) begin
    r_rx_shift <= w_rx_shift_nxt;
    r_tx_shift <= w_tx_shift_nxt;
  end

  // Transmit: txd is registered and drops on the same edge that accepts the load.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt + CNT_W'(1);
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_shift_nxt = r_tx_shift;
    w_txd_nxt      = r_txd;
    w_tx_accept    = 1'b0;
    w_tx_done      = 1'b0;
    case (r_tx_state)
      S_IDLE: begin
        w_txd_nxt    = 1'b1;
        w_tx_cnt_nxt = '0;
        if (outr_ld && r_fgo) begin
          w_tx_accept    = 1'b1;
          w_tx_shift_nxt = outr_data;
          w_txd_nxt      = 1'b0;
          w_tx_state_nxt = S_START;
        end
      end
      S_START: begin
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_cnt_nxt   = '0;
          w_tx_bit_nxt   = '0;
          w_txd_nxt      = r_tx_shift[0];
          w_tx_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_cnt_nxt   = '0;
          w_tx_bit_nxt   = r_tx_bit + 3'd1;
          w_tx_shift_nxt = {1'b1, r_tx_shift[7:1]};
          w_txd_nxt      = (r_tx_bit == 3'd7) ? 1'b1 : r_tx_shift[1];
          if (r_tx_bit == 3'd7) w_tx_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_cnt_nxt   = '0;
          w_tx_done      = 1'b1;
          w_txd_nxt      = 1'b1;
          w_tx_state_nxt = S_IDLE;
        end
      end
      default: w_tx_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_tx_state <= S_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_txd      <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_txd      <= w_txd_nxt;
    end
  end

  // CPU-facing flags; an ack coinciding with a new byte lets the byte through.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_fgi <= 1'b0;
      r_fgo <= 1'b1;
      r_irq <= 1'b0;
      r_ovr <= 1'b0;
      r_inp <= 8'h00;
    end else begin
      r_irq <= ien & (r_fgi | r_fgo);
      if (w_rx_valid) begin
        if (!r_fgi || inp_ack) begin
          r_inp <= r_rx_shift;
          r_fgi <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (inp_ack) begin
        r_fgi <= 1'b0;
      end
      if (w_tx_accept)    r_fgo <= 1'b0;
      else if (w_tx_done) r_fgo <= 1'b1;
    end
  end

  assign txd        = r_txd;
  assign inp_r      = r_inp;
  assign fgi        = r_fgi;
  assign fgo        = r_fgo;
  assign irq        = r_irq;
  assign rx_overrun = r_ovr;
endmodule

// File: doc/io_terminal.md
# io_terminal

Peripheral-side terminal for the basic computer's I/O registers. It converts a serial 8N1 line into the CPU's input register `inp_r` and serializes bytes the CPU loads via `outr_ld` onto a transmit line. It owns the FGI/FGO flag handshake and the interrupt request. It sits between the CPU datapath (AC, INPR/OUTR decode) and the external terminal line.

## Interface
Parameters:
- `CLKS_PER_BIT`, 16: clk cycles per serial bit; legal values are ≥4 and even.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `clr`  in  1  reset; synchronous, active-high.
- `rxd`  in  1  serial receive line; idle high.
- `txd`  out  1  serial transmit line; idle high.
- `inp_r`  out  8  input register presented to AdderLogic/AC.
- `fgi`  out  1  input flag; 1 = `inp_r` holds an unread byte.
- `inp_ack`  in  1  CPU INP executed (AC←INPR); clears `fgi`.
- `outr_data`  in  8  byte from AC (low 8 bits).
- `outr_ld`  in  1  CPU OUT executed; load byte, start transmit.
- `fgo`  out  1  output flag; 1 = transmitter ready.
- `ien`  in  1  interrupt enable from CPU.
- `irq`  out  1  `ien & (fgi | fgo)`, registered.
- `rx_overrun`  out  1  sticky; a byte was lost because `fgi` was 1.

## Operation
- Reset values: `txd`=1, `inp_r`=0, `fgi`=0, `fgo`=1, `irq`=0, `rx_overrun`=0. Both FSMs are in IDLE.
- Receive path:
  - `rxd` passes through a 2-flop synchronizer.
  - FSM states: IDLE → START → DATA → STOP → IDLE.
  - IDLE: a synchronized low level enters START and the bit counter clears.
  - START: at `CLKS_PER_BIT/2` cycles the line is resampled. If high, the start is treated as a glitch and the FSM returns to IDLE. If low, it enters DATA.
  - DATA: 8 samples, one every `CLKS_PER_BIT` cycles, LSB first, shifted into the shift register.
  - STOP: the line is sampled one bit later. If high, the byte is valid; if low, it is a framing error, the byte is silently discarded, and the FSM returns to IDLE.
- Valid byte delivery:
  - If `fgi`=0, or `inp_ack`=1 in the same cycle: `inp_r`←byte and `fgi`←1.
  - Otherwise: `inp_r` is unchanged, `fgi` stays 1, and `rx_overrun`←1.
- `inp_ack` alone: `fgi`←0. `inp_r` holds its value.
- Transmit path:
  - FSM states: IDLE → START → DATA → STOP → IDLE.
  - `outr_ld` with `fgo`=1: latch `outr_data`, set `fgo`←0, and enter START.
  - `outr_ld` with `fgo`=0 is ignored; the in-flight byte is not corrupted.
  - Each bit is held for `CLKS_PER_BIT` cycles. Order: start bit 0, data LSB first, stop bit 1.
  - At the end of the stop bit, `fgo`←1 and the FSM returns to IDLE.
- `rx_overrun` clears only on `clr`.
- `clr` mid-operation aborts both FSMs immediately. `txd` is 1 on the next edge and any partial receive byte is lost.

## Timing
- `txd` falls on the first edge after the `outr_ld` edge.
- `fgo` returns to 1 exactly `10*CLKS_PER_BIT` cycles after `txd` falls.
- A back-to-back `outr_ld` in the same cycle `fgo` rises is accepted. The next start bit begins on the following edge, with no idle gap beyond the stop bit.
- Receive latency: `fgi` rises 2 cycles (synchronizer) plus the mid-stop-bit sample point plus 1 cycle after the start-bit falling edge on `rxd`. That is ≈ `9.5*CLKS_PER_BIT + 3` cycles.
- `irq` lags its flag inputs by one cycle.
- `inp_ack` and `outr_ld` are single-cycle pulses. Holding `inp_ack` high is harmless. Holding `outr_ld` high sends a new byte each time `fgo` rises.

## Configuration
- `IO_TERMINAL_LOOPBACK_EN` defined: the receive synchronizer input is driven from the internal `txd` and `rxd` is ignored. Every transmitted byte appears in `inp_r` with `fgi` set.
- `IO_TERMINAL_LOOPBACK_EN` undefined: the receiver samples `rxd`. This is the normal build.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
- Reset: assert `clr` for 1 cycle mid-transmit → next cycle `txd`=1, `fgo`=1, `fgi`=0, `inp_r`=0x00, `rx_overrun`=0.
- Transmit: `outr_ld` with 0xA5 → `txd` pattern 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. `fgo`=0 for 40 cycles, then 1. A second `outr_ld` with 0xFF during transmit is ignored.
- Receive and ack:
  - Drive 0x3C on `rxd` → `fgi`=1, `inp_r`=0x3C.
  - Pulse `inp_ack` → `fgi`=0, `inp_r` still 0x3C.
- Overrun:
  - Receive 0x11 without ack, then 0x22 → `inp_r`=0x11, `rx_overrun`=1.
  - Repeat with `inp_ack` coinciding with 0x22 completion → `inp_r`=0x22, `fgi`=1, no new overrun.
- Glitch and framing:
  - 1-cycle low pulse on `rxd` → no `fgi`.
  - A byte with stop bit 0 → discarded, `fgi` unchanged.
- Interrupt and loopback:
  - `ien`=1 after reset → `irq`=1 one cycle later (`fgo`=1).
  - With `IO_TERMINAL_LOOPBACK_EN`, send 0x5A → `inp_r`=0x5A, `fgi`=1.
